// File: rtl/calc_pkg.sv
// Shared encodings for the calculator entry path: FSM states, operator codes
// and the largest value an NDIGITS-digit decimal operand can hold.
package calc_pkg;

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_OP  = 3'd1,
        S_B   = 3'd2,
        S_RES = 3'd3,
        S_MUL = 3'd4
    } state_t;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MUL  = 2'd3;

    function automatic int max_val(input int ndigits);
        int p;
        p = 1;
        for (int i = 0; i < ndigits; i++) p = p * 10;
        return p - 1;
    endfunction

endpackage

// File: rtl/calc_seq_mul.sv
// Start/done shift-add multiplier: W iterations over a 2*W product. done_o is
// high in the last iteration cycle and product_o then carries the final product.
module calc_seq_mul #(
    parameter int W = 14
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] acc_q, mcand_q, acc_d;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;

    assign acc_d     = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign done_o    = (cnt_q == CW'(1));
    assign product_o = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= CW'(W);
        end else if (cnt_q != '0) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/calc_entry_fsm.sv
// Keypad-event consumer: builds two decimal operands, applies an operator on "="
// and drives the display value. Define CALC_MUL_EN to enable the multiply path.
//
// state | meaning
// S_A   | entering operand A
// S_OP  | operator latched, waiting for first digit of B
// S_B   | entering operand B
// S_RES | result on display
// S_MUL | sequential multiply in progress
module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int VAL_W   = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_press,
    input  logic             is_num,
    input  logic             is_op,
    input  logic             is_eq,
    input  logic [3:0]       num_val,
    input  logic [1:0]       op_val,
    output logic [VAL_W-1:0] disp_val,
    output logic             disp_neg,
    output logic             disp_ovf,
    output logic             result_valid,
    output logic             busy,
    output logic [2:0]       state_dbg
);
    localparam logic [VAL_W-1:0] MAX_V = VAL_W'(max_val(NDIGITS));
    localparam int CNT_W = $clog2(NDIGITS + 1);

    state_t           state_q;
    logic             press_q;
    logic [VAL_W-1:0] a_q, b_q, disp_val_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic             neg_q, ovf_q, rv_q;

    logic             evt, op_ok, ev_eq, ev_op, ev_num, cnt_lt;
    logic [VAL_W-1:0] opnd_cur, opnd_acc_d;
    logic [VAL_W:0]   sum;

    assign evt = btn_press & ~press_q;
`ifdef CALC_MUL_EN
    assign op_ok = (op_val != OP_NONE);
`else
    assign op_ok = (op_val == OP_ADD) || (op_val == OP_SUB);
`endif
    // eq outranks op outranks num; a higher-priority flag with a bad code still swallows the event
    assign ev_eq  = evt & is_eq;
    assign ev_op  = evt & ~is_eq & is_op & op_ok;
    assign ev_num = evt & ~is_eq & ~is_op & is_num & (num_val <= 4'd9);

    assign cnt_lt     = (cnt_q < CNT_W'(NDIGITS));
    assign opnd_cur   = (state_q == S_B) ? b_q : a_q;
    assign opnd_acc_d = opnd_cur * VAL_W'(10) + VAL_W'(num_val);
    assign sum        = {1'b0, a_q} + {1'b0, b_q};

`ifdef CALC_MUL_EN
    logic               mul_start, mul_done, busy_q;
    logic [2*VAL_W-1:0] mul_prod;

    assign mul_start = (state_q == S_B) && ev_eq && (op_q == OP_MUL);

    calc_seq_mul #(.W(VAL_W)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (a_q),
        .b_i       (b_q),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_A;
            press_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            op_q       <= OP_NONE;
            disp_val_q <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            rv_q       <= 1'b0;
`ifdef CALC_MUL_EN
            busy_q     <= 1'b0;
`endif
        end else begin
            press_q <= btn_press;
            rv_q    <= 1'b0;
            case (state_q)
                S_A: begin
                    if (ev_num && cnt_lt) begin
                        a_q        <= opnd_acc_d;
                        disp_val_q <= opnd_acc_d;
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end else if (ev_op) begin
                        op_q    <= op_val;
                        state_q <= S_OP;
                    end
                end
                S_OP: begin
                    if (ev_num) begin
                        b_q        <= VAL_W'(num_val);
                        disp_val_q <= VAL_W'(num_val);
                        cnt_q      <= CNT_W'(1);
                        state_q    <= S_B;
                    end else if (ev_op) begin
                        op_q <= op_val;
                    end
                end
                S_B: begin
                    if (ev_num && cnt_lt) begin
                        b_q        <= opnd_acc_d;
                        disp_val_q <= opnd_acc_d;
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end else if (ev_eq) begin
                        if (op_q == OP_ADD) begin
                            ovf_q      <= (sum > {1'b0, MAX_V});
                            disp_val_q <= (sum > {1'b0, MAX_V}) ? '0 : sum[VAL_W-1:0];
                            neg_q      <= 1'b0;
                            rv_q       <= 1'b1;
                            state_q    <= S_RES;
                        end else if (op_q == OP_SUB) begin
                            disp_val_q <= (a_q >= b_q) ? a_q - b_q : b_q - a_q;
                            neg_q      <= (a_q < b_q);
                            ovf_q      <= 1'b0;
                            rv_q       <= 1'b1;
                            state_q    <= S_RES;
                        end
`ifdef CALC_MUL_EN
                        else if (op_q == OP_MUL) begin
                            busy_q  <= 1'b1;
                            state_q <= S_MUL;
                        end
`endif
                    end
                end
                S_RES: begin
                    if (ev_num) begin
                        a_q        <= VAL_W'(num_val);
                        disp_val_q <= VAL_W'(num_val);
                        cnt_q      <= CNT_W'(1);
                        neg_q      <= 1'b0;
                        ovf_q      <= 1'b0;
                        state_q    <= S_A;
                    end else if (ev_op && !neg_q && !ovf_q) begin
                        a_q     <= disp_val_q;
                        op_q    <= op_val;
                        state_q <= S_OP;
                    end
                end
`ifdef CALC_MUL_EN
                S_MUL: begin
                    if (mul_done) begin
                        ovf_q      <= (mul_prod > (2*VAL_W)'(MAX_V));
                        disp_val_q <= (mul_prod > (2*VAL_W)'(MAX_V)) ? '0 : mul_prod[VAL_W-1:0];
                        neg_q      <= 1'b0;
                        rv_q       <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_RES;
                    end
                end
`endif
                default: state_q <= S_A;
            endcase
        end
    end

    assign disp_val     = disp_val_q;
    assign disp_neg     = neg_q;
    assign disp_ovf     = ovf_q;
    assign result_valid = rv_q;
    assign state_dbg    = state_q;

endmodule
